// File: rtl/gpr_scoreboard.sv
// Issue scoreboard for the two-write-port GPR: tracks registers awaiting a long-latency
// writeback and holds Decode on RAW/WAW hazards or when too many long ops are in flight.
module gpr_scoreboard #(
    parameter int MAX_OUT   = 4,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iss_valid,
    output logic        iss_ready,
    input  logic [4:0]  iss_rs1,
    input  logic        iss_rs1_use,
    input  logic [4:0]  iss_rs2,
    input  logic        iss_rs2_use,
    input  logic [4:0]  iss_rd,
    input  logic        iss_rd_we,
    input  logic        iss_long,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    output logic [31:0] pend_mask,
    output logic [3:0]  out_cnt,
    output logic        err
);

    localparam logic [3:0] CNT_MAX = MAX_OUT[3:0];

    logic [31:0] wb_hot;
    logic [31:0] set_hot;
    logic [31:0] p_eff;
    logic [31:0] pend_nxt;
    logic        bypass;
    logic        raw1;
    logic        raw2;
    logic        waw;
    logic        full;
    logic        accept;
    logic        inc;

    assign bypass = wb_valid & WB_BYPASS;

    always_comb begin
        wb_hot = '0;
        if (wb_valid) begin
            wb_hot[wb_rd] = 1'b1;
        end
    end

    // Pending view seen by issue: a same-cycle writeback already satisfies the hazard when bypassing.
    assign p_eff = pend_mask & ~(bypass ? wb_hot : 32'h0);

    assign raw1 = iss_rs1_use & p_eff[iss_rs1];
    assign raw2 = iss_rs2_use & p_eff[iss_rs2];
    assign waw  = iss_rd_we & (iss_rd != 5'd0) & p_eff[iss_rd];
    assign full = iss_long & (out_cnt == CNT_MAX) & ~bypass;

    assign iss_ready = ~(raw1 | raw2 | waw | full);
    assign accept    = iss_valid & iss_ready;
    assign inc       = accept & iss_long;

    always_comb begin
        set_hot = '0;
        if (inc && iss_rd_we && (iss_rd != 5'd0)) begin
            set_hot[iss_rd] = 1'b1;
        end
    end

    // Set wins over a same-index clear; x0 can never be pending.
    assign pend_nxt = ((pend_mask & ~wb_hot) | set_hot) & ~32'h1;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_mask <= '0;
            out_cnt   <= '0;
            err       <= 1'b0;
        end else begin
            pend_mask <= pend_nxt;
            if (inc && !wb_valid) begin
                if (out_cnt != CNT_MAX) begin
                    out_cnt <= out_cnt + 4'd1;
                end
            end else if (wb_valid && !inc) begin
                if (out_cnt != 4'd0) begin
                    out_cnt <= out_cnt - 4'd1;
                end else begin
                    err <= 1'b1;
                end
            end
            if (wb_valid && (wb_rd != 5'd0) && !pend_mask[wb_rd]) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gpr_scoreboard.sv
// Directed bench for gpr_scoreboard (MAX_OUT=4, WB_BYPASS=1) with hand-computed expectations.
module tb_gpr_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        iss_valid;
    logic        iss_ready;
    logic [4:0]  iss_rs1;
    logic        iss_rs1_use;
    logic [4:0]  iss_rs2;
    logic        iss_rs2_use;
    logic [4:0]  iss_rd;
    logic        iss_rd_we;
    logic        iss_long;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] pend_mask;
    logic [3:0]  out_cnt;
    logic        err;

    int n_run  = 0;
    int n_fail = 0;

    gpr_scoreboard #(.MAX_OUT(4), .WB_BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_rs1(iss_rs1), .iss_rs1_use(iss_rs1_use),
        .iss_rs2(iss_rs2), .iss_rs2_use(iss_rs2_use),
        .iss_rd(iss_rd), .iss_rd_we(iss_rd_we), .iss_long(iss_long),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .pend_mask(pend_mask), .out_cnt(out_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        iss_valid = 0; iss_rs1 = 0; iss_rs1_use = 0; iss_rs2 = 0; iss_rs2_use = 0;
        iss_rd = 0; iss_rd_we = 0; iss_long = 0; wb_valid = 0; wb_rd = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic issue(input logic lng, input logic [4:0] rd, input logic we);
        iss_valid = 1; iss_long = lng; iss_rd = rd; iss_rd_we = we;
    endtask

    task automatic wb(input logic [4:0] rd);
        wb_valid = 1; wb_rd = rd;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pm, input logic [3:0] cnt, input logic e);
        chk({tag, ".pend"}, pend_mask, pm);
        chk({tag, ".cnt"}, {28'h0, out_cnt}, {28'h0, cnt});
        chk({tag, ".err"}, {31'h0, err}, {31'h0, e});
    endtask

    initial begin
        idle();
        // 1: reset with busy inputs present
        reset = 1;
        issue(1, 5'd5, 1); wb(5'd3); iss_rs1 = 5'd5; iss_rs1_use = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_state("reset", 32'h0, 4'd0, 1'b0);
        chk("reset.ready", {31'h0, iss_ready}, 32'h1);
        reset = 0;
        idle(); #1;

        // 2: RAW stall and same-cycle writeback bypass
        issue(1, 5'd5, 1); #1;
        chk("raw.issue_ready", {31'h0, iss_ready}, 32'h1);
        tick();
        chk_state("raw.pend5", 32'h0000_0020, 4'd1, 1'b0);
        issue(0, 5'd6, 1); iss_rs1 = 5'd5; iss_rs1_use = 1; #1;
        chk("raw.stall", {31'h0, iss_ready}, 32'h0);
        wb(5'd5); #1;
        chk("raw.bypass", {31'h0, iss_ready}, 32'h1);
        tick();
        chk_state("raw.cleared", 32'h0, 4'd0, 1'b0);

        // 3: long op to x0, then WAW on x7
        issue(1, 5'd0, 1); tick();
        chk_state("x0.long", 32'h0, 4'd1, 1'b0);
        issue(1, 5'd7, 1); tick();
        chk_state("waw.pend7", 32'h0000_0080, 4'd2, 1'b0);
        issue(0, 5'd7, 1); #1;
        chk("waw.stall", {31'h0, iss_ready}, 32'h0);
        tick();
        issue(0, 5'd7, 1); wb(5'd0); #1;
        chk("waw.stall_wb0", {31'h0, iss_ready}, 32'h0);
        tick();
        chk_state("waw.after_wb0", 32'h0000_0080, 4'd1, 1'b0);
        issue(0, 5'd7, 1); wb(5'd7); #1;
        chk("waw.release", {31'h0, iss_ready}, 32'h1);
        tick();
        chk_state("waw.done", 32'h0, 4'd0, 1'b0);

        // 4: outstanding limit
        for (int i = 1; i <= 4; i++) begin
            issue(1, 5'(i), 1); tick();
        end
        chk_state("full.four", 32'h0000_001E, 4'd4, 1'b0);
        issue(1, 5'd8, 1); #1;
        chk("full.stall", {31'h0, iss_ready}, 32'h0);
        idle(); issue(0, 5'd9, 1); iss_rs1 = 5'd10; iss_rs1_use = 1; #1;
        chk("full.short_ok", {31'h0, iss_ready}, 32'h1);
        tick();
        chk_state("full.after_short", 32'h0000_001E, 4'd4, 1'b0);
        iss_rs2 = 5'd3; iss_rs2_use = 1; #1;
        chk("rs2.stall", {31'h0, iss_ready}, 32'h0);
        iss_rs2_use = 0; #1;
        chk("rs2.unused", {31'h0, iss_ready}, 32'h1);
        idle();
        issue(1, 5'd8, 1); wb(5'd1); #1;
        chk("full.wb_bypass", {31'h0, iss_ready}, 32'h1);
        tick();
        chk_state("full.swap", 32'h0000_011C, 4'd4, 1'b0);
        wb(5'd2); tick(); wb(5'd3); tick(); wb(5'd4); tick(); wb(5'd8); tick();
        chk_state("full.drained", 32'h0, 4'd0, 1'b0);

        // 5: simultaneous writeback and reissue of x9
        issue(1, 5'd9, 1); tick();
        chk_state("sim.pend9", 32'h0000_0200, 4'd1, 1'b0);
        issue(1, 5'd9, 1); wb(5'd9); #1;
        chk("sim.ready", {31'h0, iss_ready}, 32'h1);
        tick();
        chk_state("sim.kept", 32'h0000_0200, 4'd1, 1'b0);
        wb(5'd9); tick();
        chk_state("sim.cleared", 32'h0, 4'd0, 1'b0);

        // 6: spurious writeback sets sticky err; reset mid-operation
        wb(5'd12); tick();
        chk_state("err.set", 32'h0, 4'd0, 1'b1);
        tick();
        chk("err.sticky", {31'h0, err}, 32'h1);
        issue(1, 5'd1, 1); tick(); issue(1, 5'd2, 1); tick(); issue(1, 5'd3, 1); tick();
        chk_state("rst.busy", 32'h0000_000E, 4'd3, 1'b1);
        reset = 1; issue(1, 5'd4, 1); wb(5'd1);
        @(posedge clk); #1;
        reset = 0; idle(); #1;
        chk_state("rst.mid", 32'h0, 4'd0, 1'b0);
        chk("rst.ready", {31'h0, iss_ready}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
